// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - pipelined Wishbone instruction prefetcher with redirect flush
// Optional: define FETCH_PREFETCH_ERR_EN to treat wb_err_i as a faulting, halting response.

module fetch_prefetch_unit #(
   parameter int            AW       = 32,
   parameter int            DEPTH    = 4,
   parameter logic [AW-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk_i,
   input  logic          rst_i,
   output logic          wb_cyc_o,
   output logic          wb_stb_o,
   output logic          wb_we_o,
   output logic [3:0]    wb_sel_o,
   output logic [AW-1:0] wb_adr_o,
   input  logic [31:0]   wb_dat_i,
   input  logic          wb_ack_i,
   input  logic          wb_err_i,
   input  logic          wb_stall_i,
   input  logic          redirect_i,
   input  logic [AW-1:0] redirect_pc_i,
   output logic          instr_valid_o,
   input  logic          instr_ready_i,
   output logic [31:0]   instr_o,
   output logic [AW-1:0] instr_pc_o,
   output logic          instr_fault_o
);
   localparam int            PW      = $clog2(DEPTH);
   localparam int            CW      = PW + 1;
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

   logic [AW-1:0] fetch_pc_q, fetch_pc_d;
   logic [AW-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic          halt_q, halt_d;
   logic [31:0]   data_q  [DEPTH];
   logic [31:0]   data_d  [DEPTH];
   logic [AW-1:0] pc_q    [DEPTH];
   logic [AW-1:0] pc_d    [DEPTH];
   logic          fault_q [DEPTH];
   logic          fault_d [DEPTH];
   logic [CW:0]   inflight;
   logic          issue, accept, resp, resp_err, push, pop;
   logic          unused_in;

`ifdef FETCH_PREFETCH_ERR_EN
   assign resp_err  = wb_err_i;
   assign unused_in = ^redirect_pc_i[1:0];
`else
   assign resp_err  = 1'b0;
   assign unused_in = ^{redirect_pc_i[1:0], wb_err_i};
`endif

   // Buffer slots are reserved at request time, so a push can never find the FIFO full.
   assign inflight = {1'b0, count_q} + {1'b0, outst_q};
   assign issue    = ~halt_q & (inflight < DEPTH_C);

   assign wb_stb_o = issue & ~rst_i;
   assign wb_cyc_o = ~rst_i & (issue | (outst_q != '0));
   assign wb_we_o  = 1'b0;
   assign wb_sel_o = 4'hF;
   assign wb_adr_o = fetch_pc_q;

   assign accept = wb_stb_o & ~wb_stall_i;
   assign resp   = (wb_ack_i | resp_err) & (outst_q != '0);
   assign push   = resp & ~redirect_i & (drop_q == '0);

   assign instr_valid_o = (count_q != '0);
   assign pop           = instr_valid_o & instr_ready_i & ~redirect_i;
   assign instr_o       = instr_valid_o ? data_q[rd_q] : 32'h0;
   assign instr_pc_o    = instr_valid_o ? pc_q[rd_q] : '0;
   assign instr_fault_o = instr_valid_o & fault_q[rd_q];

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      drop_d     = drop_q;
      halt_d     = halt_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      data_d     = data_q;
      pc_d       = pc_q;
      fault_d    = fault_q;

      outst_d = outst_q + CW'(accept) - CW'(resp);
      count_d = count_q + CW'(push) - CW'(pop);

      if (accept) begin
         fetch_pc_d = fetch_pc_q + AW'(4);
      end
      // Responses return in order, so resp_pc_q is always the PC of the oldest live request.
      if (push) begin
         data_d[wr_q]  = resp_err ? 32'h0 : wb_dat_i;
         pc_d[wr_q]    = resp_pc_q;
         fault_d[wr_q] = resp_err;
         wr_d          = wr_q + PW'(1);
         resp_pc_d     = resp_pc_q + AW'(4);
         if (resp_err) begin
            halt_d = 1'b1;
         end
      end
      if (resp && !redirect_i && (drop_q != '0)) begin
         drop_d = drop_q - CW'(1);
      end
      if (pop) begin
         rd_d = rd_q + PW'(1);
      end

      // Everything still owed after this edge belongs to the old stream and must be discarded.
      if (redirect_i) begin
         fetch_pc_d = {redirect_pc_i[AW-1:2], 2'b00};
         resp_pc_d  = {redirect_pc_i[AW-1:2], 2'b00};
         drop_d     = outst_d;
         halt_d     = 1'b0;
         count_d    = '0;
         wr_d       = '0;
         rd_d       = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
         count_q    <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         halt_q     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i]  <= 32'h0;
            pc_q[i]    <= '0;
            fault_q[i] <= 1'b0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         count_q    <= count_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         halt_q     <= halt_d;
         data_q     <= data_d;
         pc_q       <= pc_d;
         fault_q    <= fault_d;
      end
   end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - self-checking bench for fetch_prefetch_unit
// Reference: in-order Wishbone slave queue plus an expected-PC stream model.

module tb_fetch_prefetch_unit;
   localparam int          AW       = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          wb_cyc_o, wb_stb_o, wb_we_o;
   logic [3:0]    wb_sel_o;
   logic [AW-1:0] wb_adr_o;
   logic [31:0]   wb_dat_i = 32'h0;
   logic          wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_stall_i = 1'b0;
   logic          redirect_i = 1'b0;
   logic [AW-1:0] redirect_pc_i = '0;
   logic          instr_valid_o, instr_ready_i = 1'b0, instr_fault_o;
   logic [31:0]   instr_o;
   logic [AW-1:0] instr_pc_o;

   fetch_prefetch_unit #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
      .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
      .wb_stall_i(wb_stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o),
      .instr_pc_o(instr_pc_o), .instr_fault_o(instr_fault_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] adr;
      int          due;
   } req_t;

   req_t        pending[$];
   logic [31:0] acc_log[$];
   int          n_cmp = 0, n_err = 0;
   int          e = 0;
   int          stall_pct = 0, ready_pct = 0, lat_min = 1, lat_max = 1;
   bit          force_stall = 0, ack_en = 1, err_en = 0, chk_model = 1, redir_req = 0;
   logic [31:0] redir_pc = 32'h0, err_adr = 32'h0, exp_pc = 32'h0, salt = 32'h0;
   logic [31:0] fault_pc = 32'h0, fault_data = 32'h0, first_pc = 32'h0, a0 = 32'h0;
   logic [31:0] rnd_pc = 32'h0;
   int          pop_n = 0, fault_n = 0, n0 = 0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234 ^ salt;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: slave, redirect and decode decisions are all made at the falling edge.
   task automatic tick();
      req_t r;
      @(negedge clk);
      if (pending.size() != 0) chk("cyc_while_owed", wb_cyc_o, 1'b1);
      chk("outstanding_bound", pending.size() <= DEPTH, 1'b1);
      wb_stall_i = force_stall || ($urandom_range(0, 99) < stall_pct);
      wb_ack_i   = 1'b0;
      wb_err_i   = 1'b0;
      wb_dat_i   = $urandom;
      if (ack_en && pending.size() != 0 && pending[0].due <= e) begin
         r = pending.pop_front();
         if (err_en && r.adr == err_adr) wb_err_i = 1'b1;
         else begin
            wb_ack_i = 1'b1;
            wb_dat_i = mem(r.adr);
         end
      end
      if (wb_stb_o && !wb_stall_i) begin
         r.adr = wb_adr_o;
         r.due = e + int'($urandom_range(lat_min, lat_max));
         pending.push_back(r);
         acc_log.push_back(wb_adr_o);
      end
      redirect_i    = redir_req;
      redirect_pc_i = redir_pc;
      redir_req     = 0;
      instr_ready_i = ($urandom_range(0, 99) < ready_pct);
      if (instr_valid_o && instr_ready_i && !redirect_i) begin
         pop_n++;
         if (pop_n == 1) first_pc = instr_pc_o;
         if (instr_fault_o) begin
            fault_n++;
            fault_pc   = instr_pc_o;
            fault_data = instr_o;
         end
         if (chk_model) begin
            chk("pop_pc", instr_pc_o, exp_pc);
            chk("pop_data", instr_o, mem(exp_pc));
            chk("pop_fault", instr_fault_o, 1'b0);
         end
         exp_pc = exp_pc + 32'd4;
      end
      if (redirect_i) exp_pc = redir_pc;
      e++;
   endtask

   task automatic rst_on();
      #1 rst_i = 1'b1;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_stall_i = 1'b0;
      redirect_i = 1'b0; instr_ready_i = 1'b0;
      pending.delete();
      #1 chk("stb_in_reset", wb_stb_o, 1'b0);
   endtask

   task automatic rst_off();
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
      acc_log.delete();
      pop_n = 0; fault_n = 0; exp_pc = RESET_PC;
      #1;
      chk("stb_after_reset", wb_stb_o, 1'b1);
      chk("adr_after_reset", wb_adr_o, RESET_PC);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      salt = $urandom;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stb", wb_stb_o, 1'b0);
      chk("rst_cyc", wb_cyc_o, 1'b0);
      chk("rst_valid", instr_valid_o, 1'b0);
      chk("rst_fault", instr_fault_o, 1'b0);
      chk("rst_adr", wb_adr_o, RESET_PC);
      chk("rst_instr", instr_o, 32'h0);
      chk("rst_instr_pc", instr_pc_o, 32'h0);
      chk("we_const", wb_we_o, 1'b0);
      chk("sel_const", wb_sel_o, 4'hF);
      rst_off();

      // Streaming at one instruction per cycle
      ready_pct = 100; stall_pct = 0; lat_min = 1; lat_max = 1; ack_en = 1;
      tick(); tick();
      chk("no_pop_before_latency", pop_n, 0);
      tick();
      chk("first_pop_latency", pop_n, 1);
      repeat (9) tick();
      chk("steady_one_per_cycle", pop_n, 10);
      chk("adr_seq0", acc_log[0], 32'h0);
      chk("adr_seq1", acc_log[1], 32'h4);
      chk("adr_seq2", acc_log[2], 32'h8);
      chk("adr_seq3", acc_log[3], 32'hC);

      // Stall holds the request
      force_stall = 1;
      tick();
      a0 = wb_adr_o;
      n0 = acc_log.size();
      repeat (5) begin
         tick();
         chk("stall_stb", wb_stb_o, 1'b1);
         chk("stall_adr", wb_adr_o, a0);
         chk("stall_cyc", wb_cyc_o, 1'b1);
      end
      chk("stall_no_accept", acc_log.size(), n0);
      force_stall = 0;
      tick();
      chk("stall_release_accept", acc_log[acc_log.size()-1], a0);

      // Decode back-pressure fills exactly DEPTH slots
      rst_on(); rst_off();
      ready_pct = 0;
      repeat (10) tick();
      chk("full_accepts", acc_log.size(), DEPTH);
      chk("full_stb", wb_stb_o, 1'b0);
      chk("full_valid", instr_valid_o, 1'b1);
      chk("full_head_pc", instr_pc_o, 32'h0);
      chk("full_head_data", instr_o, mem(32'h0));
      ready_pct = 100;
      tick();
      ready_pct = 0;
      repeat (3) tick();
      chk("refill_accepts", acc_log.size(), DEPTH + 1);
      chk("refill_adr", acc_log[DEPTH], 32'h10);
      chk("refill_stb", wb_stb_o, 1'b0);

      // Redirect with 3 outstanding
      rst_on(); rst_off();
      ready_pct = 0; ack_en = 0;
      repeat (3) tick();
      chk("redir_owed", pending.size(), 3);
      force_stall = 1; redir_req = 1; redir_pc = 32'h100;
      tick();
      force_stall = 0; ack_en = 1; ready_pct = 100;
      tick();
      chk("redir_stb", wb_stb_o, 1'b1);
      chk("redir_adr", wb_adr_o, 32'h100);
      chk("redir_valid_cleared", instr_valid_o, 1'b0);
      chk("redir_first_accept", acc_log[3], 32'h100);
      for (int i = 0; i < 40 && pop_n < 4; i++) tick();
      chk("redir_pops", pop_n >= 4, 1'b1);
      chk("redir_first_pc", first_pc, 32'h100);

      // Address wrap
      redir_req = 1; redir_pc = 32'hFFFF_FFF8;
      tick();
      n0 = pop_n;
      for (int i = 0; i < 40 && pop_n < n0 + 4; i++) tick();
      chk("wrap_pops", pop_n >= n0 + 4, 1'b1);

      // Randomized traffic with random redirects
      stall_pct = 25; ready_pct = 60; lat_min = 1; lat_max = 4;
      n0 = pop_n;
      repeat (2000) begin
         if ($urandom_range(0, 99) < 3) begin
            rnd_pc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) rnd_pc = 32'hFFFF_FFF0 | (rnd_pc & 32'hC);
            redir_req = 1; redir_pc = rnd_pc;
         end
         tick();
      end
      chk("random_progress", pop_n > n0 + 200, 1'b1);

      // Bus error on 0x8
      rst_on(); rst_off();
      stall_pct = 0; ready_pct = 100; lat_min = 1; lat_max = 1;
      chk_model = 0; err_en = 1; err_adr = 32'h8;
      repeat (10) tick();
`ifdef FETCH_PREFETCH_ERR_EN
      chk("err_fault_entries", fault_n, 1);
      chk("err_fault_pc", fault_pc, 32'h8);
      chk("err_fault_data", fault_data, 32'h0);
      chk("err_halt_stb", wb_stb_o, 1'b0);
      chk("err_halt_accepts", acc_log.size(), 4);
      err_en = 0; redir_req = 1; redir_pc = 32'h40;
      tick(); tick();
      chk("err_unhalt_stb", wb_stb_o, 1'b1);
      chk("err_unhalt_adr", wb_adr_o, 32'h40);
`else
      chk("err_ignored_no_fault", fault_n, 0);
      chk("err_ignored_no_halt", acc_log.size() >= 8, 1'b1);
`endif
      err_en = 0;

      // Asynchronous reset with 2 outstanding
      rst_on(); rst_off();
      chk_model = 1; ready_pct = 0; ack_en = 1;
      tick(); tick();
      ack_en = 0;
      tick();
      @(posedge clk);
      #2;
      chk("pre_rst_owed", pending.size(), 2);
      chk("pre_rst_valid", instr_valid_o, 1'b1);
      chk("pre_rst_cyc", wb_cyc_o, 1'b1);
      rst_i = 1'b1;
      #1;
      chk("async_rst_cyc", wb_cyc_o, 1'b0);
      chk("async_rst_stb", wb_stb_o, 1'b0);
      chk("async_rst_valid", instr_valid_o, 1'b0);
      rst_on(); rst_off();
      ack_en = 1; ready_pct = 100;
      repeat (10) tick();
      chk("post_rst_pops", pop_n >= 5, 1'b1);
      chk("post_rst_first_pc", first_pc, RESET_PC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
